// File: rtl/sdram_pkg.sv
// Shared SDRAM responder definitions: command encodings, mode-register fields,
// bank state and burst-address helpers.
package sdram_pkg;

   // Command encodings as {cs, ras, cas, we}
   localparam logic [3:0] CMD_LMR       = 4'b0000;
   localparam logic [3:0] CMD_REFRESH   = 4'b0001;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_READ      = 4'b0101;
   localparam logic [3:0] CMD_TERMINATE = 4'b0110;
   localparam logic [3:0] CMD_NOP       = 4'b0111;

   localparam int MODE_BL_LSB = 0;
   localparam int MODE_BL_MSB = 2;
   localparam int MODE_IL_BIT = 3;
   localparam int MODE_CL_LSB = 4;
   localparam int MODE_CL_MSB = 6;
   localparam int MODE_WS_BIT = 9;
   localparam int A_PRE_ALL_BIT = 10;

   localparam int T_RCD = 3;
   localparam int T_RP  = 3;
   localparam int T_RFC = 7;

   typedef enum logic {
      BANK_IDLE   = 1'b0,
      BANK_ACTIVE = 1'b1
   } bank_state_t;

   // bl_code holds log2(burst length); cl3 selects CAS latency 3 over 2
   typedef struct packed {
      logic [1:0] bl_code;
      logic       interleaved;
      logic       cl3;
      logic       write_single;
   } mode_t;

   localparam mode_t MODE_RESET = '{bl_code: 2'd2, interleaved: 1'b0, cl3: 1'b0, write_single: 1'b0};

   function automatic logic [3:0] burst_len(input logic [1:0] bl_code);
      return 4'd1 << bl_code;
   endfunction

   // Low three column bits of beat n, wrapped inside the BL-aligned block
   function automatic logic [2:0] burst_offset(input logic [2:0] base, input logic [2:0] n,
                                               input logic [1:0] bl_code, input logic interleaved);
      logic [2:0] mask;
      logic [2:0] low;
      mask = 3'((4'd1 << bl_code) - 4'd1);
      low  = interleaved ? (base ^ n) : (base + n);
      return (base & ~mask) | (low & mask);
   endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Backing store for the SDRAM responder, indexed {bank,row,col}; one registered
// read port and one write port. Contents are never cleared.
module sdram_resp_mem #(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 6
) (
   input  logic                             clk,
   input  logic                             re,
   input  logic [2+ROW_BITS+COL_BITS-1:0]   raddr,
   output logic [31:0]                      rdata,
   input  logic                             we,
   input  logic [2+ROW_BITS+COL_BITS-1:0]   waddr,
   input  logic [31:0]                      wdata
);

   localparam int DEPTH = 1 << (2 + ROW_BITS + COL_BITS);

   logic [31:0] mem_reg [DEPTH];
   logic [31:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
      if (re) begin
         rdata_reg <= mem_reg[raddr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device responder: bank tracking, mode register, read/write bursts.
// Define SDRAM_RESP_TIMING_CHECK_EN to add tRCD/tRP/tRFC checking on err_timing.
module sdram_responder
   import sdram_pkg::*;
#(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sdram_cle,
   input  logic        sdram_cs,
   input  logic        sdram_ras,
   input  logic        sdram_cas,
   input  logic        sdram_we,
   input  logic        sdram_dqm,
   input  logic [1:0]  sdram_ba,
   input  logic [12:0] sdram_a,
   input  logic [31:0] sdram_dqi,
   output logic [31:0] sdram_dqo,
   output logic        sdram_dq_oe,
   output logic        err_proto,
   output logic        err_timing
);

   localparam int AW = 2 + ROW_BITS + COL_BITS;

   logic [3:0] cmd;
   logic       cmd_valid;
   logic       is_act, is_rd, is_wr, is_term, is_pre, is_ref, is_lmr;
   logic       pre_all;
   logic       act_start, rd_start, wr_start, rw_start, truncate, proto_viol;
   logic [3:0] bank_active;
   logic [ROW_BITS-1:0] bank_row [4];
   mode_t      mode_reg;
   logic [1:0] start_bl;
   logic       unused_bits;

   assign cmd       = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
   assign cmd_valid = sdram_cle && !sdram_cs;
   assign is_act    = cmd_valid && (cmd == CMD_ACTIVE);
   assign is_rd     = cmd_valid && (cmd == CMD_READ);
   assign is_wr     = cmd_valid && (cmd == CMD_WRITE);
   assign is_term   = cmd_valid && (cmd == CMD_TERMINATE);
   assign is_pre    = cmd_valid && (cmd == CMD_PRECHARGE);
   assign is_ref    = cmd_valid && (cmd == CMD_REFRESH);
   assign is_lmr    = cmd_valid && (cmd == CMD_LMR);
   assign pre_all   = sdram_a[A_PRE_ALL_BIT];
   assign unused_bits = ^sdram_a;

   assign act_start  = is_act && !bank_active[sdram_ba];
   assign rd_start   = is_rd && bank_active[sdram_ba];
   assign wr_start   = is_wr && bank_active[sdram_ba];
   assign rw_start   = rd_start || wr_start;
   assign proto_viol = (is_act && bank_active[sdram_ba]) ||
                       ((is_rd || is_wr) && !bank_active[sdram_ba]) ||
                       (is_ref && (|bank_active));
   assign start_bl   = (wr_start && mode_reg.write_single) ? 2'd0 : mode_reg.bl_code;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         bank_state_t         state_reg;
         logic [ROW_BITS-1:0] row_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_reg <= BANK_IDLE;
               row_reg   <= '0;
            end else if (act_start && (sdram_ba == 2'(gi))) begin
               state_reg <= BANK_ACTIVE;
               row_reg   <= sdram_a[ROW_BITS-1:0];
            end else if (is_pre && (pre_all || (sdram_ba == 2'(gi)))) begin
               state_reg <= BANK_IDLE;
            end
         end
         assign bank_active[gi] = (state_reg == BANK_ACTIVE);
         assign bank_row[gi]    = row_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_reg <= MODE_RESET;
      end else if (is_lmr) begin
         // Reserved burst-length codes fall back to a single beat
         mode_reg.bl_code      <= sdram_a[MODE_BL_MSB] ? 2'd0 : sdram_a[MODE_BL_LSB +: 2];
         mode_reg.interleaved  <= sdram_a[MODE_IL_BIT];
         mode_reg.cl3          <= (sdram_a[MODE_CL_MSB:MODE_CL_LSB] == 3'd3);
         mode_reg.write_single <= sdram_a[MODE_WS_BIT];
      end
   end

   // Burst engine: beat 0 is issued straight from the command, later beats from the registers
   logic                burst_active_reg, burst_active_next;
   logic                burst_write_reg, burst_write_next;
   logic [1:0]          burst_bank_reg, burst_bank_next;
   logic [ROW_BITS-1:0] burst_row_reg, burst_row_next;
   logic [COL_BITS-1:0] burst_col_reg, burst_col_next;
   logic [2:0]          burst_cnt_reg, burst_cnt_next;
   logic [1:0]          burst_bl_reg, burst_bl_next;
   logic                burst_il_reg, burst_il_next;

   logic [1:0]          beat_bank;
   logic [ROW_BITS-1:0] beat_row;
   logic [COL_BITS-1:0] beat_col;
   logic [2:0]          beat_n, beat_off;
   logic [1:0]          beat_bl;
   logic                beat_il, beat_read, beat_write;
   logic [AW-1:0]       beat_addr;

   assign truncate = is_term || (is_pre && (pre_all || (sdram_ba == burst_bank_reg)));

   always_comb begin
      burst_active_next = burst_active_reg;
      burst_write_next  = burst_write_reg;
      burst_bank_next   = burst_bank_reg;
      burst_row_next    = burst_row_reg;
      burst_col_next    = burst_col_reg;
      burst_cnt_next    = burst_cnt_reg;
      burst_bl_next     = burst_bl_reg;
      burst_il_next     = burst_il_reg;
      beat_bank  = burst_bank_reg;
      beat_row   = burst_row_reg;
      beat_col   = burst_col_reg;
      beat_n     = burst_cnt_reg;
      beat_bl    = burst_bl_reg;
      beat_il    = burst_il_reg;
      beat_read  = 1'b0;
      beat_write = 1'b0;
      if (rw_start) begin
         beat_bank  = sdram_ba;
         beat_row   = bank_row[sdram_ba];
         beat_col   = sdram_a[COL_BITS-1:0];
         beat_n     = 3'd0;
         beat_bl    = start_bl;
         beat_il    = mode_reg.interleaved;
         beat_read  = rd_start;
         beat_write = wr_start && !sdram_dqm;
         burst_active_next = (start_bl != 2'd0);
         burst_write_next  = wr_start;
         burst_bank_next   = sdram_ba;
         burst_row_next    = bank_row[sdram_ba];
         burst_col_next    = sdram_a[COL_BITS-1:0];
         burst_cnt_next    = 3'd1;
         burst_bl_next     = start_bl;
         burst_il_next     = mode_reg.interleaved;
      end else if (truncate) begin
         burst_active_next = 1'b0;
      end else if (sdram_cle && burst_active_reg) begin
         beat_read      = !burst_write_reg;
         beat_write     = burst_write_reg && !sdram_dqm;
         burst_cnt_next = burst_cnt_reg + 3'd1;
         if (({1'b0, burst_cnt_reg} + 4'd1) == burst_len(burst_bl_reg)) begin
            burst_active_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_active_reg <= 1'b0;
         burst_write_reg  <= 1'b0;
         burst_bank_reg   <= '0;
         burst_row_reg    <= '0;
         burst_col_reg    <= '0;
         burst_cnt_reg    <= '0;
         burst_bl_reg     <= '0;
         burst_il_reg     <= 1'b0;
      end else begin
         burst_active_reg <= burst_active_next;
         burst_write_reg  <= burst_write_next;
         burst_bank_reg   <= burst_bank_next;
         burst_row_reg    <= burst_row_next;
         burst_col_reg    <= burst_col_next;
         burst_cnt_reg    <= burst_cnt_next;
         burst_bl_reg     <= burst_bl_next;
         burst_il_reg     <= burst_il_next;
      end
   end

   assign beat_off  = burst_offset(beat_col[2:0], beat_n, beat_bl, beat_il);
   assign beat_addr = {beat_bank, beat_row, beat_col[COL_BITS-1:3], beat_off};

   logic [31:0] mem_rdata;

   sdram_resp_mem #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) u_mem (
      .clk   (clk),
      .re    (beat_read),
      .raddr (beat_addr),
      .rdata (mem_rdata),
      .we    (beat_write),
      .waddr (beat_addr),
      .wdata (sdram_dqi)
   );

   // Read-data pipeline: memory stage, optional CL3 delay stage, output register
   logic        s1_valid_reg, s2_valid_reg, dq_oe_reg, err_proto_reg;
   logic [31:0] s2_data_reg, dqo_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg  <= 1'b0;
         s2_valid_reg  <= 1'b0;
         s2_data_reg   <= '0;
         dqo_reg       <= '0;
         dq_oe_reg     <= 1'b0;
         err_proto_reg <= 1'b0;
      end else begin
         if (proto_viol) begin
            err_proto_reg <= 1'b1;
         end
         if (sdram_cle) begin
            s1_valid_reg <= beat_read;
            s2_valid_reg <= s1_valid_reg;
            s2_data_reg  <= mem_rdata;
            if (mode_reg.cl3) begin
               dq_oe_reg <= s2_valid_reg;
               dqo_reg   <= s2_valid_reg ? s2_data_reg : '0;
            end else begin
               dq_oe_reg <= s1_valid_reg;
               dqo_reg   <= s1_valid_reg ? mem_rdata : '0;
            end
         end
      end
   end

   assign sdram_dqo   = dqo_reg;
   assign sdram_dq_oe = dq_oe_reg;
   assign err_proto   = err_proto_reg;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
   // Counters hold the number of cycles still forbidden after each command
   logic [3:0] rcd_busy, rp_busy;
   logic [2:0] rfc_cnt_reg;
   logic       ref_start, timing_viol, err_timing_reg;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_timing
         logic [1:0] rcd_cnt_reg, rp_cnt_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rcd_cnt_reg <= '0;
               rp_cnt_reg  <= '0;
            end else begin
               if (act_start && (sdram_ba == 2'(gi))) begin
                  rcd_cnt_reg <= 2'(T_RCD - 1);
               end else if (rcd_cnt_reg != 2'd0) begin
                  rcd_cnt_reg <= rcd_cnt_reg - 2'd1;
               end
               if (is_pre && (pre_all || (sdram_ba == 2'(gi)))) begin
                  rp_cnt_reg <= 2'(T_RP - 1);
               end else if (rp_cnt_reg != 2'd0) begin
                  rp_cnt_reg <= rp_cnt_reg - 2'd1;
               end
            end
         end
         assign rcd_busy[gi] = (rcd_cnt_reg != 2'd0);
         assign rp_busy[gi]  = (rp_cnt_reg != 2'd0);
      end
   endgenerate

   assign ref_start   = is_ref && !(|bank_active);
   assign timing_viol = ((is_rd || is_wr) && rcd_busy[sdram_ba]) ||
                        (is_act && rp_busy[sdram_ba]) ||
                        (cmd_valid && (cmd != CMD_NOP) && (rfc_cnt_reg != 3'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rfc_cnt_reg    <= '0;
         err_timing_reg <= 1'b0;
      end else begin
         if (ref_start) begin
            rfc_cnt_reg <= 3'(T_RFC - 1);
         end else if (rfc_cnt_reg != 3'd0) begin
            rfc_cnt_reg <= rfc_cnt_reg - 3'd1;
         end
         if (timing_viol) begin
            err_timing_reg <= 1'b1;
         end
      end
   end

   assign err_timing = err_timing_reg;
`else
   assign err_timing = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder; expectations are hand-computed
// and honour SDRAM_RESP_TIMING_CHECK_EN for the timing-error case.
`timescale 1ns/1ps
module tb_sdram_responder;
   import sdram_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sdram_cle = 1'b1;
   logic        sdram_cs = 1'b0, sdram_ras = 1'b1, sdram_cas = 1'b1, sdram_we = 1'b1;
   logic        sdram_dqm = 1'b0;
   logic [1:0]  sdram_ba = 2'd0;
   logic [12:0] sdram_a = 13'd0;
   logic [31:0] sdram_dqi = 32'd0;
   logic [31:0] sdram_dqo;
   logic        sdram_dq_oe, err_proto, err_timing;

   int tests_run = 0;
   int tests_failed = 0;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
   localparam logic TIMING_EN = 1'b1;
`else
   localparam logic TIMING_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   sdram_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sdram_cle   (sdram_cle),
      .sdram_cs    (sdram_cs),
      .sdram_ras   (sdram_ras),
      .sdram_cas   (sdram_cas),
      .sdram_we    (sdram_we),
      .sdram_dqm   (sdram_dqm),
      .sdram_ba    (sdram_ba),
      .sdram_a     (sdram_a),
      .sdram_dqi   (sdram_dqi),
      .sdram_dqo   (sdram_dqo),
      .sdram_dq_oe (sdram_dq_oe),
      .err_proto   (err_proto),
      .err_timing  (err_timing)
   );

   // Drive one command, let the DUT sample it, return 1 ns after that edge
   task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr,
                        input logic [31:0] d, input logic m);
      {sdram_cs, sdram_ras, sdram_cas, sdram_we} = c;
      sdram_ba  = b;
      sdram_a   = addr;
      sdram_dqi = d;
      sdram_dqm = m;
      @(posedge clk);
      #1;
      $display("[TB] t=%0t cmd=%b ba=%0d a=%h dqi=%h dqm=%b -> dqo=%h oe=%b ep=%b et=%b",
               $time, c, b, addr, d, m, sdram_dqo, sdram_dq_oe, err_proto, err_timing);
   endtask

   task automatic nop();
      issue(CMD_NOP, 2'd0, 13'd0, 32'd0, 1'b0);
   endtask

   task automatic test_reset();
      nop();
      nop();
      tests_run++;
      if (sdram_dqo !== 32'd0) begin tests_failed++; $display("FAIL reset_dqo: got %h want 0", sdram_dqo); end
      tests_run++;
      if (sdram_dq_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b want 0", sdram_dq_oe); end
      tests_run++;
      if (err_proto !== 1'b0) begin tests_failed++; $display("FAIL reset_err_proto: got %b want 0", err_proto); end
      tests_run++;
      if (err_timing !== 1'b0) begin tests_failed++; $display("FAIL reset_err_timing: got %b want 0", err_timing); end
      rst_n = 1'b1;
      nop();
   endtask

   task automatic test_basic();
      issue(CMD_ACTIVE, 2'd1, 13'd3, 32'd0, 1'b0);
      repeat (3) nop();
      issue(CMD_WRITE, 2'd1, 13'd8, 32'hDEADBEEF, 1'b0);
      repeat (3) nop();
      issue(CMD_READ, 2'd1, 13'd8, 32'd0, 1'b0);
      nop();
      tests_run++;
      if (sdram_dqo !== 32'hDEADBEEF || sdram_dq_oe !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_beat0: got dqo=%h oe=%b want DEADBEEF/1", sdram_dqo, sdram_dq_oe);
      end
      tests_run++;
      if (err_proto !== 1'b0 || err_timing !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_errors: got proto=%b timing=%b want 0/0", err_proto, err_timing);
      end
      nop();
      tests_run++;
      if (sdram_dqo !== 32'd0 || sdram_dq_oe !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_beat1: got dqo=%h oe=%b want 0/1", sdram_dqo, sdram_dq_oe);
      end
      nop();
      nop();
      nop();
      tests_run++;
      if (sdram_dqo !== 32'd0 || sdram_dq_oe !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_idle_bus: got dqo=%h oe=%b want 0/0", sdram_dqo, sdram_dq_oe);
      end
   endtask

   task automatic test_burst_order();
      logic [31:0] exp_seq [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
      logic [31:0] exp_il  [4] = '{32'd4, 32'd3, 32'd2, 32'd1};
      issue(CMD_LMR, 2'd0, 13'h002, 32'd0, 1'b0);
      issue(CMD_WRITE, 2'd1, 13'd6, 32'd1, 1'b0);
      issue(CMD_NOP, 2'd0, 13'd0, 32'd2, 1'b0);
      issue(CMD_NOP, 2'd0, 13'd0, 32'd3, 1'b0);
      issue(CMD_NOP, 2'd0, 13'd0, 32'd4, 1'b0);
      nop();
      issue(CMD_READ, 2'd1, 13'd6, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         nop();
         tests_run++;
         if (sdram_dqo !== exp_seq[i] || sdram_dq_oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL seq_beat%0d: got dqo=%h oe=%b want %h/1", i, sdram_dqo, sdram_dq_oe, exp_seq[i]);
         end
      end
      issue(CMD_LMR, 2'd0, 13'h00A, 32'd0, 1'b0);
      issue(CMD_READ, 2'd1, 13'd5, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         nop();
         tests_run++;
         if (sdram_dqo !== exp_il[i] || sdram_dq_oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL il_beat%0d: got dqo=%h oe=%b want %h/1", i, sdram_dqo, sdram_dq_oe, exp_il[i]);
         end
      end
      nop();
   endtask

   task automatic test_cas3_truncate();
      logic [31:0] exp_v [5] = '{32'd1, 32'd3, 32'd4, 32'd1, 32'd2};
      issue(CMD_LMR, 2'd0, 13'h032, 32'd0, 1'b0);
      issue(CMD_READ, 2'd1, 13'd6, 32'd0, 1'b0);
      issue(CMD_READ, 2'd1, 13'd4, 32'd0, 1'b0);
      tests_run++;
      if (sdram_dq_oe !== 1'b0) begin tests_failed++; $display("FAIL cl3_early: got oe=%b want 0", sdram_dq_oe); end
      for (int i = 0; i < 5; i++) begin
         nop();
         tests_run++;
         if (sdram_dqo !== exp_v[i] || sdram_dq_oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL cl3_beat%0d: got dqo=%h oe=%b want %h/1", i, sdram_dqo, sdram_dq_oe, exp_v[i]);
         end
      end
      nop();
      tests_run++;
      if (sdram_dq_oe !== 1'b0) begin tests_failed++; $display("FAIL cl3_end: got oe=%b want 0", sdram_dq_oe); end
      issue(CMD_LMR, 2'd0, 13'h002, 32'd0, 1'b0);
   endtask

   task automatic test_proto();
      issue(CMD_READ, 2'd2, 13'd0, 32'd0, 1'b0);
      tests_run++;
      if (err_proto !== 1'b1) begin tests_failed++; $display("FAIL proto_set: got %b want 1", err_proto); end
      for (int i = 0; i < 3; i++) begin
         nop();
         tests_run++;
         if (sdram_dq_oe !== 1'b0) begin tests_failed++; $display("FAIL proto_no_read%0d: got oe=%b want 0", i, sdram_dq_oe); end
      end
      repeat (3) nop();
      tests_run++;
      if (err_proto !== 1'b1) begin tests_failed++; $display("FAIL proto_sticky: got %b want 1", err_proto); end
   endtask

   task automatic test_timing();
      issue(CMD_ACTIVE, 2'd2, 13'd1, 32'd0, 1'b0);
      tests_run++;
      if (err_timing !== 1'b0) begin tests_failed++; $display("FAIL timing_before: got %b want 0", err_timing); end
      issue(CMD_READ, 2'd2, 13'd0, 32'd0, 1'b0);
      tests_run++;
      if (err_timing !== TIMING_EN) begin
         tests_failed++;
         $display("FAIL timing_trcd: got %b want %b", err_timing, TIMING_EN);
      end
      repeat (5) nop();
      issue(CMD_PRECHARGE, 2'd2, 13'd0, 32'd0, 1'b0);
      repeat (3) nop();
   endtask

   task automatic test_dqm_mask();
      issue(CMD_LMR, 2'd0, 13'h001, 32'd0, 1'b0);
      issue(CMD_WRITE, 2'd1, 13'h010, 32'hAAAA_0001, 1'b0);
      issue(CMD_NOP, 2'd0, 13'd0, 32'hBBBB_0002, 1'b0);
      issue(CMD_WRITE, 2'd1, 13'h010, 32'hCCCC_0003, 1'b0);
      issue(CMD_NOP, 2'd0, 13'd0, 32'hDDDD_0004, 1'b1);
      nop();
      issue(CMD_READ, 2'd1, 13'h010, 32'd0, 1'b0);
      nop();
      tests_run++;
      if (sdram_dqo !== 32'hCCCC_0003) begin tests_failed++; $display("FAIL dqm_beat0: got %h want CCCC0003", sdram_dqo); end
      nop();
      tests_run++;
      if (sdram_dqo !== 32'hBBBB_0002) begin tests_failed++; $display("FAIL dqm_beat1_kept: got %h want BBBB0002", sdram_dqo); end
      nop();
   endtask

   task automatic test_reset_mid_read();
      issue(CMD_READ, 2'd1, 13'h010, 32'd0, 1'b0);
      nop();
      tests_run++;
      if (sdram_dq_oe !== 1'b1) begin tests_failed++; $display("FAIL midrd_active: got oe=%b want 1", sdram_dq_oe); end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (sdram_dq_oe !== 1'b0 || sdram_dqo !== 32'd0) begin
         tests_failed++;
         $display("FAIL midrd_async_drop: got dqo=%h oe=%b want 0/0", sdram_dqo, sdram_dq_oe);
      end
      tests_run++;
      if (err_proto !== 1'b0) begin tests_failed++; $display("FAIL midrd_proto_clear: got %b want 0", err_proto); end
      nop();
      tests_run++;
      if (sdram_dq_oe !== 1'b0) begin tests_failed++; $display("FAIL midrd_held: got oe=%b want 0", sdram_dq_oe); end
      rst_n = 1'b1;
      issue(CMD_REFRESH, 2'd0, 13'd0, 32'd0, 1'b0);
      repeat (7) nop();
      issue(CMD_ACTIVE, 2'd1, 13'd3, 32'd0, 1'b0);
      repeat (3) nop();
      issue(CMD_READ, 2'd1, 13'h010, 32'd0, 1'b0);
      nop();
      tests_run++;
      if (sdram_dqo !== 32'hCCCC_0003 || sdram_dq_oe !== 1'b1) begin
         tests_failed++;
         $display("FAIL retain_beat0: got dqo=%h oe=%b want CCCC0003/1", sdram_dqo, sdram_dq_oe);
      end
      nop();
      tests_run++;
      if (sdram_dqo !== 32'hBBBB_0002 || sdram_dq_oe !== 1'b1) begin
         tests_failed++;
         $display("FAIL retain_beat1: got dqo=%h oe=%b want BBBB0002/1", sdram_dqo, sdram_dq_oe);
      end
      tests_run++;
      if (err_proto !== 1'b0 || err_timing !== 1'b0) begin
         tests_failed++;
         $display("FAIL refresh_errors: got proto=%b timing=%b want 0/0", err_proto, err_timing);
      end
      repeat (3) nop();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_burst_order();
      test_cas3_truncate();
      test_proto();
      test_timing();
      test_dqm_mask();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
